rv32i_instruction_fetch: RTL and testbench

//  Fetch stage directly upstream of instruction decode. Holds the PC and issues in-order word

---
 rtl/rv32i_instruction_fetch.sv | 130 +++++++++++++
 tb/tb_rv32i_instruction_fetch.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_instruction_fetch.sv
// RV32I fetch stage: holds the PC, issues credit-limited in-order imem requests and
// buffers {pc, instruction} pairs for decode; a redirect flushes and drops stale responses.
module rv32i_instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH-1:0][31:0] buf_instr_q, buf_pc_q;

    logic          pop, push, req_fire;
    logic [CW-1:0] credit_used;
    logic [31:0]   redirect_tgt;
    logic          unused_redirect_lsb;

    assign redirect_tgt        = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign if_valid       = (count_q != '0);
    assign pop            = if_valid && if_ready;
    assign if_instruction = if_valid ? buf_instr_q[rd_ptr_q] : 32'h0;
    assign if_pc          = if_valid ? buf_pc_q[rd_ptr_q] : 32'h0;

    // A slot freed by this cycle's pop counts as credit, so back-to-back fetch is
    // sustained at depth 2; credit never shrinks without an accept, so a pending
    // request stays asserted until taken.
    assign credit_used    = outstanding_q + count_q - (pop ? CNT_ONE : '0);
    assign imem_req_valid = (state_q != BOOT) && !redirect_valid && (credit_used < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign push           = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        if (req_fire) begin
            outstanding_d = outstanding_d + CNT_ONE;
            fetch_pc_d    = fetch_pc_q + 32'd4;
        end
        if (imem_rsp_valid)
            outstanding_d = outstanding_d - CNT_ONE;
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old stream.
            fetch_pc_d = redirect_tgt;
            rsp_pc_d   = redirect_tgt;
            drop_cnt_d = outstanding_d;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            state_d    = (outstanding_d != '0) ? DRAIN : RUN;
        end else begin
            if (imem_rsp_valid) begin
                if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CNT_ONE;
                else                  rsp_pc_d   = rsp_pc_q + 32'd4;
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)      count_d = count_q + CNT_ONE;
            else if (!push && pop) count_d = count_q - CNT_ONE;
            case (state_q)
                BOOT:    state_d = RUN;
                DRAIN:   if (drop_cnt_d == '0) state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr_q[wr_ptr_q] <= imem_rsp_data;
            buf_pc_q[wr_ptr_q]    <= rsp_pc_q;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(push && !pop && (count_q == DEPTH_C)));

endmodule

// File: tb/tb_rv32i_instruction_fetch.sv
// Bench for rv32i_instruction_fetch: memory model, transaction-level expected stream
// (queue of fetched PCs flushed on redirect), negedge monitor, directed + random phases.
module tb_rv32i_instruction_fetch;
    localparam int DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid, if_ready;
    logic [31:0] if_instruction, if_pc;

    rv32i_instruction_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instruction(if_instruction), .if_pc(if_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // ---------------- instruction memory model ----------------
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mem_q[$];
    int lat_min = 1, lat_max = 1;
    int last_due = 0;

    initial begin
        mreq_t r;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_q.delete();
                last_due = 0;
            end else if (imem_req_valid && imem_req_ready) begin
                r.addr = imem_req_addr;
                r.due  = cyc + int'($urandom_range(lat_max, lat_min));
                if (r.due < last_due) r.due = last_due;
                last_due = r.due;
                mem_q.push_back(r);
            end
            @(posedge clk);
            #1;
            if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = imem_word(mem_q[0].addr);
                void'(mem_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
            end
        end
    end

    // ---------------- reference model: expected delivery stream ----------------
    logic [31:0] exp_q[$];
    logic [31:0] model_addr = RST_PC;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          fire_cnt = 0;

    always @(negedge clk) begin
        #1;
        if (rst) begin
            exp_q.delete();
            model_addr = RST_PC;
            pend       = 1'b0;
            fire_cnt   = 0;
        end else begin
            if (pend && !redirect_valid) begin
                check("req_hold_valid", {31'b0, imem_req_valid}, 32'd1);
                check("req_hold_addr", imem_req_addr, pend_addr);
            end
            if (redirect_valid) begin
                check("req_valid_in_redirect", {31'b0, imem_req_valid}, 32'd0);
                exp_q.delete();
                model_addr = {redirect_pc[31:2], 2'b00};
            end else if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, model_addr);
                exp_q.push_back(model_addr);
                model_addr = model_addr + 32'd4;
                fire_cnt++;
                check("credit_limit", {31'b0, exp_q.size() <= DEPTH}, 32'd1);
            end
            pend      = imem_req_valid && !imem_req_ready;
            pend_addr = imem_req_addr;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            if (if_valid && if_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_output: got pc 0x%08h, required no output (cycle %0d)", if_pc, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pc", if_pc, e);
                    check("out_instr", if_instruction, imem_word(e));
                end
            end else if (!if_valid) begin
                check("idle_outputs_zero", if_pc | if_instruction, 32'h0);
            end
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(output logic [31:0] pc, output logic [31:0] ins, output bit ok);
        ok = 1'b0; pc = 32'h0; ins = 32'h0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            #2;
            if (if_valid && if_ready) begin
                ok = 1'b1; pc = if_pc; ins = if_instruction;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
        check({tag, "_req_addr"}, imem_req_addr, RST_PC);
        check({tag, "_if_valid"}, {31'b0, if_valid}, 32'd0);
        check({tag, "_if_instr"}, if_instruction, 32'h0);
        check({tag, "_if_pc"}, if_pc, 32'h0);
    endtask

    initial begin
        int n;
        bit ok, found;
        logic [31:0] pc, ins, hold_addr;
        rst = 1'b1; if_ready = 1'b1; imem_req_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");

        // 1: first output latency and back-to-back throughput
        @(posedge clk); #1; rst = 1'b0;
        n = 0;
        do begin @(posedge clk); #2; n++; end while (!if_valid && n < 20);
        check("t1_first_valid_latency", n, 3);
        check("t1_first_pc", if_pc, RST_PC);
        n = 0;
        for (int i = 0; i < 10; i++) begin @(posedge clk); #2; if (if_valid) n++; end
        check("t1_throughput", n, 10);

        // 2: decode stalled from reset -> exactly DEPTH requests
        @(posedge clk); #1; rst = 1'b1; if_ready = 1'b0;
        step(2); rst = 1'b0;
        step(12); #1;
        check("t2_fire_count", fire_cnt, DEPTH);
        check("t2_req_valid_off", {31'b0, imem_req_valid}, 32'd0);
        if_ready = 1'b1;
        step(10);

        // 3: redirect with two requests in flight
        lat_min = 4; lat_max = 4;
        step(10);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #2;
            if (mem_q.size() + int'(imem_rsp_valid) == 2) found = 1'b1;
        end
        check("t3_two_inflight", {31'b0, found}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(posedge clk); #1; redirect_valid = 1'b0;
        wait_hs(pc, ins, ok);
        check("t3_hs_seen", {31'b0, ok}, 32'd1);
        check("t3_pc", pc, 32'h100);
        check("t3_instr", ins, imem_word(32'h100));

        // 4: redirect coinciding with a response and a decode handshake
        lat_min = 1; lat_max = 1;
        step(10);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        #1;
        check("t4_rsp_coincident", {31'b0, imem_rsp_valid}, 32'd1);
        check("t4_hs_coincident", {31'b0, if_valid & if_ready}, 32'd1);
        @(posedge clk); #1; redirect_valid = 1'b0;
        #1;
        check("t4_flushed", {31'b0, if_valid}, 32'd0);
        wait_hs(pc, ins, ok);
        check("t4_pc", pc, 32'h200);
        check("t4_instr", ins, imem_word(32'h200));

        // 5: memory back-pressure holds request; redirect replaces it
        imem_req_ready = 1'b0;
        step(3); #1;
        hold_addr = imem_req_addr;
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_valid", {31'b0, imem_req_valid}, 32'd1);
            check("t5_hold_addr", imem_req_addr, hold_addr);
            @(posedge clk); #2;
        end
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        @(posedge clk); #1; redirect_valid = 1'b0;
        #1;
        check("t5_new_valid", {31'b0, imem_req_valid}, 32'd1);
        check("t5_new_addr", imem_req_addr, 32'h300);
        imem_req_ready = 1'b1;
        step(6);

        // 6: misaligned redirect near the top of memory, wrap, then async reset
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFD;
        @(posedge clk); #1; redirect_valid = 1'b0;
        wait_hs(pc, ins, ok);
        check("t6_top_pc", pc, 32'hFFFF_FFFC);
        wait_hs(pc, ins, ok);
        check("t6_wrap_pc", pc, 32'h0000_0000);
        check("t6_wrap_instr", ins, imem_word(32'h0));
        step(3);
        #2; rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        step(2); rst = 1'b0;

        // random phase
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                lat_min = int'($urandom_range(2, 1));
                lat_max = lat_min + int'($urandom_range(3, 0));
            end
            if_ready       = ($urandom_range(99, 0) < 70);
            imem_req_ready = ($urandom_range(99, 0) < 70);
            redirect_valid = ($urandom_range(99, 0) < 3);
            redirect_pc    = $urandom;
            step(1);
        end
        redirect_valid = 1'b0; if_ready = 1'b1; imem_req_ready = 1'b1;
        step(20);
        check("final_stream_live", {31'b0, if_valid}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
